// File: rtl/fwd_pkg.sv
// Shared types and default widths for the forwarding scoreboard.
// Entry storage uses these widths, so DATA_W/REG_W overrides must match them.
package fwd_pkg;

   localparam int unsigned FWD_DATA_W = 32;
   localparam int unsigned FWD_REG_W  = 5;

   localparam logic [FWD_REG_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                  valid;
      logic [FWD_REG_W-1:0]  dst;
      logic                  ready;
      logic [FWD_DATA_W-1:0] data;
   } fwd_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Priority match of one source register against the scoreboard, youngest (entry 0) first.
module fwd_lookup
   import fwd_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  fwd_entry_t [DEPTH-1:0]  entries,
   input  logic [FWD_REG_W-1:0]    src,
   output logic                    hit,
   output logic                    pending,
   output logic [FWD_DATA_W-1:0]   data
);

   // Walk oldest to youngest so the youngest match is written last and wins.
   always_comb begin
      hit     = 1'b0;
      pending = 1'b0;
      data    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (entries[DEPTH-1-i].valid && entries[DEPTH-1-i].dst == src && src != REG_ZERO) begin
            hit     = entries[DEPTH-1-i].ready;
            pending = !entries[DEPTH-1-i].ready;
            data    = entries[DEPTH-1-i].ready ? entries[DEPTH-1-i].data : '0;
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// Shifting scoreboard of in-flight writers with operand forwarding and load-use stall.
// Optional FWD_STATS_EN builds the saturating forwarded-operand counter.
module forward_scoreboard
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_W  = FWD_DATA_W,
   parameter int unsigned REG_W   = FWD_REG_W,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      advance,
   input  logic                      issue_valid,
   input  logic [REG_W-1:0]          issue_dst,
   input  logic                      issue_ready,
   input  logic [DATA_W-1:0]         issue_data,
   input  logic                      fill_valid,
   input  logic [DATA_W-1:0]         fill_data,
   input  logic [NUM_SRC*REG_W-1:0]  src_reg,
   output logic [NUM_SRC-1:0]        src_fwd,
   output logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic                      stall,
   output logic                      err,
   output logic [CNT_W-1:0]          stall_cycles,
   output logic [CNT_W-1:0]          fwd_count
);

   fwd_entry_t [DEPTH-1:0] ent_q, ent_d;
   logic                   err_q, err_d;
   logic [NUM_SRC-1:0]     hit, pend;
   logic [CNT_W-1:0]       stall_q;
   logic                   retire_pend, fill_hit;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_lookup #(.DEPTH(DEPTH)) u_lookup (
         .entries (ent_q),
         .src     (src_reg[i*REG_W +: REG_W]),
         .hit     (hit[i]),
         .pending (pend[i]),
         .data    (src_data[i*DATA_W +: DATA_W])
      );
   end

   assign src_fwd      = hit;
   assign stall        = |pend;
   assign err          = err_q;
   assign stall_cycles = stall_q;

   always_comb begin
      ent_d       = ent_q;
      err_d       = err_q;
      retire_pend = 1'b0;
      fill_hit    = 1'b0;
      if (advance) begin
         retire_pend = ent_q[DEPTH-1].valid && !ent_q[DEPTH-1].ready;
         for (int unsigned k = DEPTH-1; k > 0; k--) ent_d[k] = ent_q[k-1];
         ent_d[0].valid = issue_valid && (issue_dst != REG_ZERO);
         ent_d[0].dst   = issue_dst;
         ent_d[0].ready = issue_ready;
         ent_d[0].data  = issue_data;
      end
      // A retiring pending entry is older than anything left, so it takes the fill first.
      if (fill_valid) begin
         fill_hit = retire_pend;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!fill_hit && ent_d[DEPTH-1-i].valid && !ent_d[DEPTH-1-i].ready) begin
               ent_d[DEPTH-1-i].ready = 1'b1;
               ent_d[DEPTH-1-i].data  = fill_data;
               fill_hit               = 1'b1;
            end
         end
      end
      if ((fill_valid && !fill_hit) || (retire_pend && !fill_valid)) err_d = 1'b1;
      if (flush) begin
         for (int unsigned k = 0; k < DEPTH; k++) ent_d[k].valid = 1'b0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_q   <= '0;
         err_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         ent_q <= ent_d;
         err_q <= err_d;
         if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] fwd_q;
   logic [CNT_W:0]   fwd_sum;

   always_comb begin
      fwd_sum = {1'b0, fwd_q};
      for (int unsigned i = 0; i < NUM_SRC; i++) fwd_sum = fwd_sum + (CNT_W+1)'(hit[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fwd_q <= '0;
      else if (advance) fwd_q <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
   end

   assign fwd_count = fwd_q;
`else
   assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: per-cycle expectations from a reference model.
module tb_forward_scoreboard;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        reset, flush, advance, issue_valid, issue_ready, fill_valid;
   logic [4:0]  issue_dst;
   logic [31:0] issue_data, fill_data;
   logic [9:0]  src_reg;
   logic [1:0]  src_fwd;
   logic [63:0] src_data;
   logic        stall, err;
   logic [15:0] stall_cycles, fwd_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   forward_scoreboard #(
      .DATA_W(32), .REG_W(5), .DEPTH(D), .NUM_SRC(2), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .advance(advance),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
      .issue_data(issue_data), .fill_valid(fill_valid), .fill_data(fill_data),
      .src_reg(src_reg), .src_fwd(src_fwd), .src_data(src_data), .stall(stall),
      .err(err), .stall_cycles(stall_cycles), .fwd_count(fwd_count)
   );

   // reference model
   logic        mv   [D];
   logic [4:0]  md   [D];
   logic        mr   [D];
   logic [31:0] mdat [D];
   logic        merr;
   logic [15:0] msc, mfc;

   typedef struct {
      logic [1:0]  fwd;
      logic [63:0] data;
      logic        stall;
      logic        err;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;
   exp_t expq[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D; i++) begin
         mv[i] = 1'b0; md[i] = '0; mr[i] = 1'b0; mdat[i] = '0;
      end
      merr = 1'b0; msc = '0; mfc = '0;
   endtask

   task automatic model_lookup(input logic [4:0] s, output logic f, output logic p,
                               output logic [31:0] d);
      f = 1'b0; p = 1'b0; d = '0;
      if (s != 5'd0) begin
         for (int i = 0; i < D; i++) begin
            if (mv[i] && md[i] == s) begin
               f = mr[i]; p = !mr[i]; d = mr[i] ? mdat[i] : 32'd0;
               break;
            end
         end
      end
   endtask

   task automatic model_edge(input logic st, input logic [1:0] fw);
      logic        nv [D];
      logic [4:0]  nd [D];
      logic        nr [D];
      logic [31:0] ndat [D];
      logic        rp, done;
      int          s;
      if (reset) begin model_reset(); return; end
      if (st && msc != 16'hFFFF) msc++;
`ifdef FWD_STATS_EN
      if (advance) begin
         s = int'(mfc) + int'(fw[0]) + int'(fw[1]);
         mfc = (s > 65535) ? 16'hFFFF : s[15:0];
      end
`else
      s = int'(fw);
`endif
      if (flush) begin
         for (int i = 0; i < D; i++) mv[i] = 1'b0;
         merr = 1'b0;
         return;
      end
      for (int i = 0; i < D; i++) begin
         nv[i] = mv[i]; nd[i] = md[i]; nr[i] = mr[i]; ndat[i] = mdat[i];
      end
      rp = 1'b0;
      if (advance) begin
         rp = mv[D-1] && !mr[D-1];
         for (int i = D-1; i > 0; i--) begin
            nv[i] = mv[i-1]; nd[i] = md[i-1]; nr[i] = mr[i-1]; ndat[i] = mdat[i-1];
         end
         nv[0] = issue_valid && issue_dst != 5'd0;
         nd[0] = issue_dst; nr[0] = issue_ready; ndat[0] = issue_data;
      end
      if (fill_valid) begin
         done = rp;
         for (int i = D-1; i >= 0; i--) begin
            if (!done && nv[i] && !nr[i]) begin
               nr[i] = 1'b1; ndat[i] = fill_data; done = 1'b1;
            end
         end
         if (!done) merr = 1'b1;
      end else if (rp) begin
         merr = 1'b1;
      end
      for (int i = 0; i < D; i++) begin
         mv[i] = nv[i]; md[i] = nd[i]; mr[i] = nr[i]; mdat[i] = ndat[i];
      end
   endtask

   // One clock: predict, compare at negedge, advance the model at posedge.
   task automatic tick();
      exp_t        e, g;
      logic        f, p;
      logic [31:0] d;
      e.fwd = '0; e.data = '0; e.stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         model_lookup(src_reg[i*5 +: 5], f, p, d);
         e.fwd[i] = f;
         e.data[i*32 +: 32] = d;
         if (p) e.stall = 1'b1;
      end
      e.err = merr; e.sc = msc; e.fc = mfc;
      expq.push_back(e);
      @(negedge clk);
      g = expq.pop_front();
      check("src_fwd", 64'(src_fwd), 64'(g.fwd));
      check("src_data", src_data, g.data);
      check("stall", 64'(stall), 64'(g.stall));
      check("err", 64'(err), 64'(g.err));
      check("stall_cycles", 64'(stall_cycles), 64'(g.sc));
      check("fwd_count", 64'(fwd_count), 64'(g.fc));
      @(posedge clk);
      model_edge(g.stall, g.fwd);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; advance = 1'b0; issue_valid = 1'b0; issue_dst = '0;
      issue_ready = 1'b0; issue_data = '0; fill_valid = 1'b0; fill_data = '0;
   endtask

   task automatic issue(input logic [4:0] dst, input logic rdy, input logic [31:0] data);
      idle();
      advance = 1'b1; issue_valid = 1'b1; issue_dst = dst; issue_ready = rdy; issue_data = data;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] base;
      idle();
      src_reg = '0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      tick();
      reset = 1'b0;
      tick();

      // youngest ready writer wins
      issue(5'd5, 1'b1, 32'h11);
      issue(5'd5, 1'b1, 32'h22);
      idle(); src_reg = {5'd0, 5'd5};
      #2;
      check("alu_fwd0", 64'(src_fwd[0]), 64'd1);
      check("alu_data0", 64'(src_data[31:0]), 64'h22);
      check("alu_stall", 64'(stall), 64'd0);
      tick();

      // load-use stall then fill
      issue(5'd8, 1'b0, 32'h0);
      idle(); src_reg = {5'd8, 5'd0};
      #2;
      check("lu_stall", 64'(stall), 64'd1);
      check("lu_fwd1", 64'(src_fwd[1]), 64'd0);
      repeat (3) tick();
      check("lu_stall_cycles", 64'(stall_cycles), 64'd3);
      fill_valid = 1'b1; fill_data = 32'hDEADBEEF;
      tick();
      idle();
      #2;
      check("lu_unstall", 64'(stall), 64'd0);
      check("lu_data1", 64'(src_data[63:32]), 64'hDEADBEEF);
      tick();

      // register zero is never forwarded
      issue(5'd0, 1'b1, 32'h99);
      idle(); src_reg = '0;
      #2;
      check("r0_fwd", 64'(src_fwd), 64'd0);
      check("r0_stall", 64'(stall), 64'd0);
      tick();

      // retiring an unready entry is sticky until flush
      issue(5'd3, 1'b0, 32'h0);
      idle(); advance = 1'b1; tick(); tick();
      idle();
      #2;
      check("retire_err", 64'(err), 64'd1);
      repeat (2) tick();
      check("retire_err_sticky", 64'(err), 64'd1);
      flush = 1'b1; tick();
      idle();
      #2;
      check("flush_err_clr", 64'(err), 64'd0);

      // flush beats a same-cycle fill; a later fill has no target
      issue(5'd4, 1'b0, 32'h0);
      idle(); flush = 1'b1; fill_valid = 1'b1; fill_data = 32'h1234; src_reg = {5'd0, 5'd4};
      tick();
      idle();
      #2;
      check("ff_err", 64'(err), 64'd0);
      check("ff_stall", 64'(stall), 64'd0);
      fill_valid = 1'b1; fill_data = 32'h5678;
      tick();
      idle();
      #2;
      check("orphan_fill_err", 64'(err), 64'd1);
      flush = 1'b1; tick();

      // fill landing on the retiring entry completes it
      issue(5'd6, 1'b0, 32'h0);
      idle(); advance = 1'b1; tick();
      fill_valid = 1'b1; fill_data = 32'hABCD; tick();
      idle();
      #2;
      check("retire_fill_err", 64'(err), 64'd0);
      tick();

      // both ports forward for four advancing cycles
      issue(5'd7, 1'b1, 32'h700);
      issue(5'd9, 1'b1, 32'h900);
      src_reg = {5'd9, 5'd7};
      base = mfc;
      for (int n = 0; n < 4; n++) issue((n % 2 == 0) ? 5'd7 : 5'd9, 1'b1, 32'(n));
      idle();
      #2;
`ifdef FWD_STATS_EN
      check("stats_fwd_count", 64'(fwd_count), 64'(base + 16'd8));
`else
      check("stats_fwd_count", 64'(fwd_count), 64'(base));
`endif

      // random traffic, with one reset in the middle
      for (int n = 0; n < 300; n++) begin
         if (n == 150) begin
            idle(); reset = 1'b1; #1; model_reset();
            tick();
            reset = 1'b0;
         end
         flush       = ($urandom_range(0, 31) == 0);
         advance     = $urandom_range(0, 1);
         issue_valid = $urandom_range(0, 3) != 0;
         issue_dst   = 5'($urandom_range(0, 7));
         issue_ready = $urandom_range(0, 2) != 0;
         issue_data  = $urandom;
         fill_valid  = ($urandom_range(0, 4) == 0);
         fill_data   = $urandom;
         src_reg     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
